phy_tx_arbiter: RTL and testbench

Shares the 32-bit PHY transmit port (data_in_tx/valid_in_tx) between two upstream requesters, lane 0 and lane 1. After reset it sequences link initialisation by sending a fixed count of IDLE words, then arbitrates with burst-limited round-robin. Output is registered and feeds the PHY TX input directly. Runs in the clk_2f domain, i.e. the word-rate clock of the PHY.

---
 rtl/phy_pkg.sv | 15 +
 rtl/phy_rr_grant.sv | 36 +++
 rtl/phy_tx_arbiter.sv | 105 ++++++++++
 tb/tb_phy_tx_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared types and constants for the PHY transmit arbiter.
package phy_pkg;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_INIT   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [31:0] IDLE_WORD_DEF = 32'hBCBCBCBC;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/phy_rr_grant.sv
// Combinational two-lane grant: burst-limited round-robin, or lane 0 strict
// priority when PHY_ARB_STRICT_PRIO_EN is defined.
module phy_rr_grant
    import phy_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int BC_W      = 3
) (
    input  logic            valid0,
    input  logic            valid1,
    input  logic            halt,
    input  logic            last_grant,
    input  logic [BC_W-1:0] burst_cnt,
    output logic            gnt_valid,
    output logic            gnt_lane
);

    always_comb begin
        gnt_valid = !halt && (valid0 || valid1);
        gnt_lane  = LANE0;
        if (valid0 && valid1) begin
`ifdef PHY_ARB_STRICT_PRIO_EN
            gnt_lane = LANE0;
`else
            // Stay on the current lane until its burst allowance is used up.
            if (burst_cnt < BC_W'(MAX_BURST))
                gnt_lane = last_grant;
            else
                gnt_lane = ~last_grant;
`endif
        end else if (valid1) begin
            gnt_lane = LANE1;
        end
    end

endmodule

// File: rtl/phy_tx_arbiter.sv
// Two-lane arbiter onto the PHY TX port (clk_2f domain): IDLE-word link init,
// then burst-limited round-robin (strict lane 0 priority with PHY_ARB_STRICT_PRIO_EN).
module phy_tx_arbiter
    import phy_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                INIT_WORDS = 4,
    parameter logic [DATA_W-1:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter int                MAX_BURST  = 4,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid0,
    input  logic [DATA_W-1:0] data0,
    output logic              ready0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data1,
    output logic              ready1,
    input  logic              halt,
    output logic [DATA_W-1:0] data_out_tx,
    output logic              valid_out_tx,
    output logic              lane_out,
    output logic              link_up,
    output logic [CNT_W-1:0]  tx_count
);

    localparam int BC_W   = $clog2(MAX_BURST + 1);
    localparam int INIT_W = $clog2(INIT_WORDS + 1);

    state_t            state;
    logic [INIT_W-1:0] init_cnt;
    logic              last_grant;
    logic [BC_W-1:0]   burst_cnt;
    logic              gnt_valid;
    logic              gnt_lane;
    logic              xfer;

    phy_rr_grant #(
        .MAX_BURST (MAX_BURST),
        .BC_W      (BC_W)
    ) u_grant (
        .valid0     (valid0),
        .valid1     (valid1),
        .halt       (halt),
        .last_grant (last_grant),
        .burst_cnt  (burst_cnt),
        .gnt_valid  (gnt_valid),
        .gnt_lane   (gnt_lane)
    );

    assign xfer   = (state == S_ACTIVE) && gnt_valid;
    assign ready0 = xfer && (gnt_lane == LANE0);
    assign ready1 = xfer && (gnt_lane == LANE1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RESET;
            init_cnt     <= '0;
            data_out_tx  <= '0;
            valid_out_tx <= 1'b0;
            lane_out     <= LANE0;
            link_up      <= 1'b0;
            tx_count     <= '0;
            last_grant   <= LANE0;
            burst_cnt    <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_INIT;
                    init_cnt <= '0;
                end
                S_INIT: begin
                    valid_out_tx <= 1'b1;
                    data_out_tx  <= IDLE_WORD;
                    if (init_cnt == INIT_W'(INIT_WORDS - 1)) begin
                        state   <= S_ACTIVE;
                        link_up <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (xfer) begin
                        data_out_tx  <= (gnt_lane == LANE1) ? data1 : data0;
                        valid_out_tx <= 1'b1;
                        lane_out     <= gnt_lane;
                        tx_count     <= tx_count + 1'b1;
                        if (gnt_lane == last_grant) begin
                            if (burst_cnt < BC_W'(MAX_BURST))
                                burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            last_grant <= gnt_lane;
                            burst_cnt  <= BC_W'(1);
                        end
                    end else begin
                        valid_out_tx <= 1'b0;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Directed bench for phy_tx_arbiter: init sequence, single-lane bursts, halt,
// round-robin burst limit (or strict priority with PHY_ARB_STRICT_PRIO_EN), mid-run reset.
module tb_phy_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid0, valid1, halt;
    logic [31:0] data0, data1;
    logic        ready0, ready1;
    logic [31:0] data_out_tx;
    logic        valid_out_tx, lane_out, link_up;
    logic [15:0] tx_count;

    int tests = 0;
    int fails = 0;

    phy_tx_arbiter #(
        .DATA_W     (32),
        .INIT_WORDS (4),
        .IDLE_WORD  (32'hBCBCBCBC),
        .MAX_BURST  (4),
        .CNT_W      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid0       (valid0),
        .data0        (data0),
        .ready0       (ready0),
        .valid1       (valid1),
        .data1        (data1),
        .ready1       (ready1),
        .halt         (halt),
        .data_out_tx  (data_out_tx),
        .valid_out_tx (valid_out_tx),
        .lane_out     (lane_out),
        .link_up      (link_up),
        .tx_count     (tx_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       exp_lane [12];
    logic [3:0] n0, n1;
    logic [31:0] exp_word;

    initial begin
        reset = 1'b1; valid0 = 1'b0; valid1 = 1'b0; halt = 1'b0;
        data0 = '0; data1 = '0;
        tick(); tick();

        // Reset state; lane valid during reset must not be accepted
        valid0 = 1'b1; data0 = 32'h12345678;
        #1;
        check("rst_data", data_out_tx, 32'h0);
        check("rst_valid", {31'b0, valid_out_tx}, 32'h0);
        check("rst_link", {31'b0, link_up}, 32'h0);
        check("rst_count", {16'b0, tx_count}, 32'h0);
        check("rst_ready0", {31'b0, ready0}, 32'h0);
        valid0 = 1'b0;

        // Release: one S_RESET cycle, then 4 IDLE words
        reset = 1'b0;
        tick();
        check("sreset_valid", {31'b0, valid_out_tx}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_valid", {31'b0, valid_out_tx}, 32'h1);
            check("idle_data", data_out_tx, 32'hBCBCBCBC);
            if (i == 0) begin
                valid0 = 1'b1;
                #1;
                check("init_ready0", {31'b0, ready0}, 32'h0);
                valid0 = 1'b0;
            end
        end
        check("link_up", {31'b0, link_up}, 32'h1);
        tick();
        check("post_init_valid", {31'b0, valid_out_tx}, 32'h0);
        check("post_init_count", {16'b0, tx_count}, 32'h0);
        check("post_init_link", {31'b0, link_up}, 32'h1);

        // Lane 0 alone: FF.., EE.., DD.., CC..
        valid0 = 1'b1;
        data0 = 32'hFFFFFFFF; #1;
        check("l0_ready0", {31'b0, ready0}, 32'h1);
        check("l0_ready1", {31'b0, ready1}, 32'h0);
        tick(); check("l0_w0", data_out_tx, 32'hFFFFFFFF);
        check("l0_lane", {31'b0, lane_out}, 32'h0);
        data0 = 32'hEEEEEEEE;
        tick(); check("l0_w1", data_out_tx, 32'hEEEEEEEE);
        data0 = 32'hDDDDDDDD;
        tick(); check("l0_w2", data_out_tx, 32'hDDDDDDDD);
        data0 = 32'hCCCCCCCC;
        tick(); check("l0_w3", data_out_tx, 32'hCCCCCCCC);
        check("l0_valid", {31'b0, valid_out_tx}, 32'h1);
        check("l0_count", {16'b0, tx_count}, 32'd4);
        valid0 = 1'b0;
        tick();
        check("l0_idle_valid", {31'b0, valid_out_tx}, 32'h0);
        check("l0_idle_hold", data_out_tx, 32'hCCCCCCCC);

        // Lane 1: two words, halt over the third, then a fourth
        valid1 = 1'b1; data1 = 32'h00000001;
        tick(); check("l1_w1", data_out_tx, 32'h00000001);
        check("l1_lane", {31'b0, lane_out}, 32'h1);
        data1 = 32'h00000002;
        tick(); check("l1_w2", data_out_tx, 32'h00000002);
        data1 = 32'h00000003; halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_ready1", {31'b0, ready1}, 32'h0);
            tick();
            check("halt_valid", {31'b0, valid_out_tx}, 32'h0);
            check("halt_hold", data_out_tx, 32'h00000002);
        end
        halt = 1'b0; #1;
        check("unhalt_ready1", {31'b0, ready1}, 32'h1);
        tick(); check("l1_w3", data_out_tx, 32'h00000003);
        check("l1_w3_valid", {31'b0, valid_out_tx}, 32'h1);
        data1 = 32'h00000004;
        tick(); check("l1_w4", data_out_tx, 32'h00000004);
        check("l1_count", {16'b0, tx_count}, 32'd8);

        // Both lanes valid; lane 1 has used its full burst of 4
`ifdef PHY_ARB_STRICT_PRIO_EN
        for (int i = 0; i < 12; i++) exp_lane[i] = 1'b0;
`else
        for (int i = 0; i < 12; i++) exp_lane[i] = (i >= 4 && i < 8);
`endif
        n0 = 4'd1; n1 = 4'd1;
        valid0 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data0 = {28'h0000000, n0};
            data1 = {28'h1000000, n1};
            #1;
            check("rr_ready0", {31'b0, ready0}, {31'b0, !exp_lane[i]});
            check("rr_ready1", {31'b0, ready1}, {31'b0, exp_lane[i]});
            exp_word = exp_lane[i] ? {28'h1000000, n1} : {28'h0000000, n0};
            if (exp_lane[i]) n1 = n1 + 1'b1; else n0 = n0 + 1'b1;
            tick();
            check("rr_data", data_out_tx, exp_word);
            check("rr_lane", {31'b0, lane_out}, {31'b0, exp_lane[i]});
        end
        check("rr_count", {16'b0, tx_count}, 32'd20);
        valid0 = 1'b0; valid1 = 1'b0;
        tick();
        check("rr_idle_valid", {31'b0, valid_out_tx}, 32'h0);

        // Reset between AAAAAAAA and 99999999
        valid0 = 1'b1; data0 = 32'hAAAAAAAA;
        tick(); check("mr_aa", data_out_tx, 32'hAAAAAAAA);
        data0 = 32'h99999999;
        reset = 1'b1; #1;
        check("mr_data", data_out_tx, 32'h0);
        check("mr_valid", {31'b0, valid_out_tx}, 32'h0);
        check("mr_link", {31'b0, link_up}, 32'h0);
        check("mr_count", {16'b0, tx_count}, 32'h0);
        check("mr_ready0", {31'b0, ready0}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("mr_sreset_valid", {31'b0, valid_out_tx}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("mr_init_ready0", {31'b0, ready0}, 32'h0);
            tick();
            check("mr_idle_data", data_out_tx, 32'hBCBCBCBC);
            check("mr_idle_valid", {31'b0, valid_out_tx}, 32'h1);
        end
        check("mr_link_up", {31'b0, link_up}, 32'h1);
        #1;
        check("mr_ready0_act", {31'b0, ready0}, 32'h1);
        tick();
        check("mr_99", data_out_tx, 32'h99999999);
        check("mr_99_lane", {31'b0, lane_out}, 32'h0);
        check("mr_99_count", {16'b0, tx_count}, 32'd1);
        valid0 = 1'b0;
        tick();
        check("mr_end_valid", {31'b0, valid_out_tx}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
